// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bridge arbiter: FSM state encoding and owner ids.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int WAIT_CNT_W = 4;
    localparam int WAIT_MAX   = (1 << WAIT_CNT_W) - 1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle linking M0 (CPU data port), M1 (DMA/debug), the arbiter and the system bridge.
interface bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_we;
    logic [DW-1:0] m0_wd;
    logic          m0_ack;

    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_we;
    logic [DW-1:0] m1_wd;
    logic          m1_ack;

    logic [DW-1:0] rdata;

    logic [AW-1:0] PrAddr;
    logic          PrWE;
    logic [DW-1:0] PrWD;
    logic [DW-1:0] PrRD;

    // The arbiter sits on the slave side of the masters and drives the bridge.
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_wd,
        input  m1_req, m1_addr, m1_we, m1_wd,
        input  PrRD,
        output m0_ack, m1_ack, rdata,
        output PrAddr, PrWE, PrWD
    );

    modport master (
        output m0_req, m0_addr, m0_we, m0_wd,
        output m1_req, m1_addr, m1_we, m1_wd,
        output PrRD,
        input  m0_ack, m1_ack, rdata,
        input  PrAddr, PrWE, PrWD
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Two-way request picker. ARB_ROUND_ROBIN_EN selects alternating tie-break; otherwise M0 wins ties.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the master that was not served last gets the bus.
    always_comb begin
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = req0 ? OWNER_M0 : OWNER_M1;
        end
    end
`else
    logic w_unusedLastGnt;

    assign w_unusedLastGnt = last_gnt;
    assign gnt_id          = req0 ? OWNER_M0 : OWNER_M1;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter sharing the single bridge port between M0 and M1; IDLE -> ACCESS -> RESP per transaction.
// Tie-break policy is chosen by the ARB_ROUND_ROBIN_EN macro (fixed M0 priority when undefined).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 0
)
(
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_badWaitCycles
        $error("bus_arbiter: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_CYCLES);

    arbState_t               r_state;
    arbState_t               w_nextState;
    logic [AW-1:0]           r_addr;
    logic                    r_we;
    logic [DW-1:0]           r_wd;
    logic                    r_owner;
    logic                    r_lastGnt;
    logic [WAIT_CNT_W-1:0]   r_waitCnt;
    logic [DW-1:0]           r_rdata;

    logic                    w_gntValid;
    logic                    w_gntId;
    logic                    w_accessDone;
    logic                    w_prWE;
    logic                    w_m0Ack;
    logic                    w_m1Ack;

    rr_pick u_pick (
        .req0      (bus.m0_req),
        .req1      (bus.m1_req),
        .last_gnt  (r_lastGnt),
        .gnt_valid (w_gntValid),
        .gnt_id    (w_gntId)
    );

    assign w_accessDone = (r_waitCnt == LAST_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The write strobe is confined to the first ACCESS cycle so side-effecting registers see one write.
    always_comb begin
        w_nextState = r_state;
        w_prWE      = 1'b0;
        w_m0Ack     = 1'b0;
        w_m1Ack     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_gntValid) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                w_prWE = r_we && (r_waitCnt == '0);
                if (w_accessDone) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_m0Ack     = (r_owner == OWNER_M0);
                w_m1Ack     = (r_owner == OWNER_M1);
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wd      <= '0;
            r_owner   <= OWNER_M0;
            r_lastGnt <= OWNER_M1;
            r_waitCnt <= '0;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gntValid) begin
                        r_owner   <= w_gntId;
                        r_addr    <= (w_gntId == OWNER_M1) ? bus.m1_addr : bus.m0_addr;
                        r_we      <= (w_gntId == OWNER_M1) ? bus.m1_we   : bus.m0_we;
                        r_wd      <= (w_gntId == OWNER_M1) ? bus.m1_wd   : bus.m0_wd;
                        r_waitCnt <= '0;
                    end
                end
                ACCESS: begin
                    if (w_accessDone) begin
                        r_rdata   <= r_we ? '0 : bus.PrRD;
                        r_waitCnt <= '0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                RESP: begin
                    r_lastGnt <= r_owner;
                end
                default: begin
                    r_waitCnt <= '0;
                end
            endcase
        end
    end

    assign bus.PrAddr = r_addr;
    assign bus.PrWD   = r_wd;
    assign bus.PrWE   = w_prWE;
    assign bus.rdata  = r_rdata;
    assign bus.m0_ack = w_m0Ack;
    assign bus.m1_ack = w_m1Ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized two-master traffic
// compared against a transaction-timeline reference model.
module tb_bus_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int WAIT  = 2;
    localparam int ACK_K = WAIT + 2;
    localparam int GAP   = WAIT + 3;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] salt;
    int          checks = 0;
    int          errors = 0;

    bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bridge read mux stand-in: address-dependent data perturbed every cycle by salt.
    function automatic logic [31:0] rdModel(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.PrRD = rdModel(bus.PrAddr) ^ salt;

    function automatic int pickModel(input bit p0, input bit p1, input int lastOwner);
        if (p0 && p1) return RR ? (1 - lastOwner) : 0;
        return p0 ? 0 : 1;
    endfunction

    task automatic tick();
        @(negedge clk);
        salt = $urandom;
    endtask

    task automatic idleInputs();
        bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_we = 1'b0; bus.m0_wd = '0;
        bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_we = 1'b0; bus.m1_wd = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        salt  = '0;
        idleInputs();
        tick();
        bus.m0_req = 1'b1;
        bus.m0_we  = 1'b1;
        tick();
        checks++; if (bus.PrAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_PrAddr: got %h expected 0", bus.PrAddr); end
        checks++; if (bus.PrWE !== 1'b0) begin errors++; $display("[TB] FAIL reset_PrWE: got %b expected 0", bus.PrWE); end
        checks++; if (bus.PrWD !== 32'h0) begin errors++; $display("[TB] FAIL reset_PrWD: got %h expected 0", bus.PrWD); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.rdata); end
        checks++; if (bus.m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_m0_ack: got %b expected 0", bus.m0_ack); end
        checks++; if (bus.m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_m1_ack: got %b expected 0", bus.m1_ack); end
        idleInputs();
        reset = 1'b0;
    endtask

    task automatic test_read();
        logic [31:0] expRd = '0;
        doReset();
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0004; bus.m0_we = 1'b0; bus.m0_wd = $urandom;
        for (int k = 1; k <= ACK_K + 1; k++) begin
            tick();
            checks++; if (bus.PrWE !== 1'b0) begin errors++; $display("[TB] FAIL read_PrWE k=%0d: got %b expected 0", k, bus.PrWE); end
            if (k <= WAIT + 1) begin
                checks++; if (bus.PrAddr !== 32'h4) begin errors++; $display("[TB] FAIL read_PrAddr k=%0d: got %h expected 4", k, bus.PrAddr); end
            end
            if (k == WAIT + 1) expRd = rdModel(32'h4) ^ salt;
            checks++; if (bus.m0_ack !== (k == ACK_K)) begin errors++; $display("[TB] FAIL read_m0_ack k=%0d: got %b expected %b", k, bus.m0_ack, (k == ACK_K)); end
            checks++; if (bus.m1_ack !== 1'b0) begin errors++; $display("[TB] FAIL read_m1_ack k=%0d: got %b expected 0", k, bus.m1_ack); end
            if (k == ACK_K) begin
                checks++; if (bus.rdata !== expRd) begin errors++; $display("[TB] FAIL read_rdata: got %h expected %h", bus.rdata, expRd); end
                bus.m0_req = 1'b0;
            end
        end
    endtask

    task automatic test_write();
        int weCount = 0;
        doReset();
        bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_7f04; bus.m1_we = 1'b1; bus.m1_wd = 32'hAAAA_0001;
        for (int k = 1; k <= ACK_K + 1; k++) begin
            tick();
            weCount += int'(bus.PrWE);
            checks++; if (bus.PrWE !== (k == 1)) begin errors++; $display("[TB] FAIL write_PrWE k=%0d: got %b expected %b", k, bus.PrWE, (k == 1)); end
            if (k <= WAIT + 1) begin
                checks++; if (bus.PrAddr !== 32'h7f04) begin errors++; $display("[TB] FAIL write_PrAddr k=%0d: got %h expected 7f04", k, bus.PrAddr); end
                checks++; if (bus.PrWD !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL write_PrWD k=%0d: got %h expected aaaa0001", k, bus.PrWD); end
            end
            checks++; if (bus.m1_ack !== (k == ACK_K)) begin errors++; $display("[TB] FAIL write_m1_ack k=%0d: got %b expected %b", k, bus.m1_ack, (k == ACK_K)); end
            checks++; if (bus.m0_ack !== 1'b0) begin errors++; $display("[TB] FAIL write_m0_ack k=%0d: got %b expected 0", k, bus.m0_ack); end
            if (k == ACK_K) begin
                checks++; if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL write_rdata: got %h expected 0", bus.rdata); end
                bus.m1_req = 1'b0;
            end
        end
        checks++; if (weCount != 1) begin errors++; $display("[TB] FAIL write_PrWE_count: got %0d expected 1", weCount); end
    endtask

    task automatic test_tie();
        logic [31:0] a [2];
        logic [31:0] expRd = '0;
        int lastOwner = 1;
        int expOwner;
        int nextAck = ACK_K;
        doReset();
        a[0] = 32'h0000_0100;
        a[1] = 32'h0000_0200;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = a[0];
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = a[1];
        expOwner = pickModel(1'b1, 1'b1, lastOwner);
        for (int k = 1; k <= ACK_K + 3 * GAP; k++) begin
            tick();
            if (k == nextAck - 1) expRd = rdModel(a[expOwner]) ^ salt;
            checks++; if (bus.m0_ack !== (k == nextAck && expOwner == 0)) begin errors++; $display("[TB] FAIL tie_m0_ack k=%0d: got %b expected %b", k, bus.m0_ack, (k == nextAck && expOwner == 0)); end
            checks++; if (bus.m1_ack !== (k == nextAck && expOwner == 1)) begin errors++; $display("[TB] FAIL tie_m1_ack k=%0d: got %b expected %b", k, bus.m1_ack, (k == nextAck && expOwner == 1)); end
            if (k == nextAck) begin
                checks++; if (bus.rdata !== expRd) begin errors++; $display("[TB] FAIL tie_rdata k=%0d: got %h expected %h", k, bus.rdata, expRd); end
                a[expOwner] = a[expOwner] + 32'h4;
                if (expOwner == 0) bus.m0_addr = a[0];
                else               bus.m1_addr = a[1];
                lastOwner = expOwner;
                expOwner  = pickModel(1'b1, 1'b1, lastOwner);
                nextAck   = nextAck + GAP;
            end
        end
        idleInputs();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] expRd = '0;
        doReset();
        bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_7f10; bus.m1_we = 1'b1; bus.m1_wd = 32'hDEAD_0010;
        tick();
        checks++; if (bus.PrWE !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_PrWE_before: got %b expected 1", bus.PrWE); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.PrWE !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_PrWE_abort: got %b expected 0", bus.PrWE); end
        checks++; if (bus.PrAddr !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_PrAddr: got %h expected 0", bus.PrAddr); end
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0020; bus.m0_we = 1'b0;
        tick();
        checks++; if ((bus.m0_ack | bus.m1_ack) !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ack_in_reset: got %b expected 0", (bus.m0_ack | bus.m1_ack)); end
        reset = 1'b0;
        for (int k = 1; k <= 2 * ACK_K + 1; k++) begin
            tick();
            if (k == WAIT + 1) expRd = rdModel(32'h20) ^ salt;
            checks++; if (bus.PrWE !== (k == ACK_K + 2)) begin errors++; $display("[TB] FAIL rstmid_PrWE k=%0d: got %b expected %b", k, bus.PrWE, (k == ACK_K + 2)); end
            checks++; if (bus.m0_ack !== (k == ACK_K)) begin errors++; $display("[TB] FAIL rstmid_m0_ack k=%0d: got %b expected %b", k, bus.m0_ack, (k == ACK_K)); end
            checks++; if (bus.m1_ack !== (k == 2 * ACK_K + 1)) begin errors++; $display("[TB] FAIL rstmid_m1_ack k=%0d: got %b expected %b", k, bus.m1_ack, (k == 2 * ACK_K + 1)); end
            if (k <= WAIT + 1) begin
                checks++; if (bus.PrAddr !== 32'h20) begin errors++; $display("[TB] FAIL rstmid_PrAddr k=%0d: got %h expected 20", k, bus.PrAddr); end
            end
            if (k == ACK_K) begin
                checks++; if (bus.rdata !== expRd) begin errors++; $display("[TB] FAIL rstmid_rdata: got %h expected %h", bus.rdata, expRd); end
                bus.m0_req = 1'b0;
            end
            if (k == ACK_K + 2) begin
                checks++; if (bus.PrAddr !== 32'h7f10) begin errors++; $display("[TB] FAIL rstmid_PrAddr_m1: got %h expected 7f10", bus.PrAddr); end
            end
            if (k == 2 * ACK_K + 1) bus.m1_req = 1'b0;
        end
    endtask

    task automatic test_drop();
        int ackCount = 0;
        doReset();
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0008; bus.m0_we = 1'b0;
        for (int k = 1; k <= ACK_K + GAP; k++) begin
            tick();
            if (k == 1) begin
                bus.m0_req  = 1'b0;
                bus.m0_addr = 32'h0000_0099;
            end
            ackCount += int'(bus.m0_ack);
            checks++; if (bus.m0_ack !== (k == ACK_K)) begin errors++; $display("[TB] FAIL drop_m0_ack k=%0d: got %b expected %b", k, bus.m0_ack, (k == ACK_K)); end
            checks++; if (bus.PrAddr !== 32'h8) begin errors++; $display("[TB] FAIL drop_PrAddr k=%0d: got %h expected 8", k, bus.PrAddr); end
        end
        checks++; if (ackCount != 1) begin errors++; $display("[TB] FAIL drop_ack_count: got %0d expected 1", ackCount); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expRd = '0;
        doReset();
        bus.m0_req = 1'b1; bus.m0_addr = 32'h0; bus.m0_we = 1'b0;
        for (int k = 1; k <= 2 * ACK_K + 1; k++) begin
            tick();
            if (k == WAIT + 1)      expRd = rdModel(32'h0) ^ salt;
            if (k == ACK_K + 2 + WAIT) expRd = rdModel(32'h4) ^ salt;
            checks++; if (bus.m0_ack !== (k == ACK_K || k == 2 * ACK_K + 1)) begin errors++; $display("[TB] FAIL b2b_m0_ack k=%0d: got %b expected %b", k, bus.m0_ack, (k == ACK_K || k == 2 * ACK_K + 1)); end
            if (k == 1 || k == ACK_K + 1) begin
                checks++; if (bus.PrAddr !== 32'h0) begin errors++; $display("[TB] FAIL b2b_PrAddr_first k=%0d: got %h expected 0", k, bus.PrAddr); end
            end
            if (k == ACK_K + 2) begin
                checks++; if (bus.PrAddr !== 32'h4) begin errors++; $display("[TB] FAIL b2b_PrAddr_second k=%0d: got %h expected 4", k, bus.PrAddr); end
            end
            if (k == ACK_K) begin
                checks++; if (bus.rdata !== expRd) begin errors++; $display("[TB] FAIL b2b_rdata_first: got %h expected %h", bus.rdata, expRd); end
                bus.m0_addr = 32'h4;
            end
            if (k == 2 * ACK_K + 1) begin
                checks++; if (bus.rdata !== expRd) begin errors++; $display("[TB] FAIL b2b_rdata_second: got %h expected %h", bus.rdata, expRd); end
                bus.m0_req = 1'b0;
            end
        end
    endtask

    // Reference model: a transaction occupies WAIT+1 access cycles then one ack cycle, then one idle cycle.
    task automatic test_random();
        bit          pend [2];
        logic [31:0] rAddr [2];
        bit          rWe [2];
        logic [31:0] rWd [2];
        int          age = 0;
        int          own = 0;
        int          lastOwner = 1;
        logic [31:0] mAddr = '0, mWd = '0, lastAddr = '0, lastWd = '0, expRd = '0;
        bit          mWe = 1'b0;
        doReset();
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; rAddr[m] = '0; rWe[m] = 1'b0; rWd[m] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            tick();
            if (age >= 1 && age <= WAIT + 1) begin
                checks++; if (bus.PrAddr !== mAddr) begin errors++; $display("[TB] FAIL rand_PrAddr c=%0d: got %h expected %h", c, bus.PrAddr, mAddr); end
                checks++; if (bus.PrWD !== mWd) begin errors++; $display("[TB] FAIL rand_PrWD c=%0d: got %h expected %h", c, bus.PrWD, mWd); end
                checks++; if (bus.PrWE !== (mWe && age == 1)) begin errors++; $display("[TB] FAIL rand_PrWE c=%0d: got %b expected %b", c, bus.PrWE, (mWe && age == 1)); end
                if (age == WAIT + 1) expRd = mWe ? 32'h0 : (rdModel(mAddr) ^ salt);
            end else begin
                checks++; if (bus.PrWE !== 1'b0) begin errors++; $display("[TB] FAIL rand_PrWE_idle c=%0d: got %b expected 0", c, bus.PrWE); end
                checks++; if (bus.PrAddr !== lastAddr) begin errors++; $display("[TB] FAIL rand_PrAddr_hold c=%0d: got %h expected %h", c, bus.PrAddr, lastAddr); end
                checks++; if (bus.PrWD !== lastWd) begin errors++; $display("[TB] FAIL rand_PrWD_hold c=%0d: got %h expected %h", c, bus.PrWD, lastWd); end
            end
            checks++; if (bus.m0_ack !== (age == ACK_K && own == 0)) begin errors++; $display("[TB] FAIL rand_m0_ack c=%0d: got %b expected %b", c, bus.m0_ack, (age == ACK_K && own == 0)); end
            checks++; if (bus.m1_ack !== (age == ACK_K && own == 1)) begin errors++; $display("[TB] FAIL rand_m1_ack c=%0d: got %b expected %b", c, bus.m1_ack, (age == ACK_K && own == 1)); end
            if (age == ACK_K) begin
                checks++; if (bus.rdata !== expRd) begin errors++; $display("[TB] FAIL rand_rdata c=%0d: got %h expected %h", c, bus.rdata, expRd); end
                pend[own] = 1'b0;
                lastOwner = own;
            end
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m]  = 1'b1;
                    rAddr[m] = $urandom & 32'hFFFF_FFFC;
                    rWe[m]   = 1'($urandom_range(0, 1));
                    rWd[m]   = $urandom;
                end
            end
            bus.m0_req = pend[0]; bus.m0_addr = rAddr[0]; bus.m0_we = rWe[0]; bus.m0_wd = rWd[0];
            bus.m1_req = pend[1]; bus.m1_addr = rAddr[1]; bus.m1_we = rWe[1]; bus.m1_wd = rWd[1];
            if (age == 0) begin
                if (pend[0] || pend[1]) begin
                    own      = pickModel(pend[0], pend[1], lastOwner);
                    mAddr    = rAddr[own];
                    mWe      = rWe[own];
                    mWd      = rWd[own];
                    lastAddr = mAddr;
                    lastWd   = mWd;
                    age      = 1;
                end
            end else if (age == ACK_K) begin
                age = 0;
            end else begin
                age = age + 1;
            end
        end
        idleInputs();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_reset_mid();
        test_drop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
